// File: rtl/branch_predictor_param.sv
// IF-stage branch predictor: 2-bit counter PHT (bimodal or gshare)
// plus a circular return-address stack for jalr returns.
module branch_predictor_param #(
    parameter int IDX_W     = 6,
    parameter int GHR_W     = 6,
    parameter int MODE      = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       pc,
    input  logic              B_type,
    input  logic              jal,
    input  logic              jalr,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Rs1,
    input  logic [31:0]       pc_add_4,
    output logic              pred_taken,
    output logic [GHR_W-1:0]  pred_ghr,
    output logic              ras_valid,
    output logic [31:0]       ras_target,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [GHR_W-1:0]  upd_ghr,
    input  logic              upd_taken
);

    localparam int NUM = 1 << IDX_W;
    localparam int PW  = $clog2(RAS_DEPTH);
    localparam logic [PW:0] L_DEPTH = (PW+1)'(RAS_DEPTH);

    logic [1:0]       r_pht [NUM];
    logic [GHR_W-1:0] r_ghr;
    logic [31:0]      r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [PW:0]      r_cnt;

    logic [IDX_W-1:0] w_phist;
    logic [IDX_W-1:0] w_uhist;
    logic [IDX_W-1:0] w_pidx;
    logic [IDX_W-1:0] w_uidx;
    logic [1:0]       w_ucnt;
    logic [GHR_W-1:0] w_ghr_nxt;
    logic [GHR_W-1:0] w_upd_shift;
    logic [GHR_W-1:0] w_pred_shift;
    logic             w_rd_link;
    logic             w_rs1_link;
    logic             w_push;
    logic             w_pop;
    logic             w_cnt_nz;
    logic             w_wr_en;
    logic [PW-1:0]    w_wr_idx;
    logic [PW-1:0]    w_ptr_nxt;
    logic [PW:0]      w_cnt_nxt;
    logic             w_unused;

    assign w_unused = ^{pc[31:IDX_W+2], pc[1:0],
                        upd_pc[31:IDX_W+2], upd_pc[1:0]};

    // Bimodal mode ignores history entirely
    assign w_phist = (MODE != 0) ? IDX_W'(r_ghr)   : '0;
    assign w_uhist = (MODE != 0) ? IDX_W'(upd_ghr) : '0;

    assign w_pidx = pc[IDX_W+1:2] ^ w_phist;
    assign w_uidx = upd_pc[IDX_W+1:2] ^ w_uhist;
    assign w_ucnt = r_pht[w_uidx];

    assign pred_taken = r_pht[w_pidx][1];
    assign pred_ghr   = r_ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                r_pht[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_taken && w_ucnt != 2'b11) begin
                r_pht[w_uidx] <= w_ucnt + 2'd1;
            end else if (!upd_taken && w_ucnt != 2'b00) begin
                r_pht[w_uidx] <= w_ucnt - 2'd1;
            end
        end
    end

    // Shift form also covers GHR_W=1: the old bit simply falls off
    assign w_upd_shift  = (upd_ghr << 1) | GHR_W'(upd_taken);
    assign w_pred_shift = (r_ghr << 1) | GHR_W'(pred_taken);

    always_comb begin
        w_ghr_nxt = r_ghr;
        if (flush) begin
            w_ghr_nxt = upd_valid ? w_upd_shift : upd_ghr;
        end else if (!stall && B_type) begin
            w_ghr_nxt = w_pred_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else begin
            r_ghr <= w_ghr_nxt;
        end
    end

    assign w_rd_link  = (Rd == 5'd1) || (Rd == 5'd5);
    assign w_rs1_link = (Rs1 == 5'd1) || (Rs1 == 5'd5);
    assign w_push     = (jal || jalr) && w_rd_link;
    assign w_pop      = jalr && w_rs1_link &&
                        !(w_rd_link && (Rd == Rs1));
    assign w_cnt_nz   = (r_cnt != '0);

    assign ras_valid  = w_pop && w_cnt_nz;
    assign ras_target = r_ras[r_ptr];

    always_comb begin
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_cnt;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_ptr;
        if (!stall && !flush) begin
            if (w_push && w_pop && w_cnt_nz) begin
                w_wr_en = 1'b1;
            end else if (w_push) begin
                w_ptr_nxt = r_ptr + PW'(1);
                w_wr_idx  = r_ptr + PW'(1);
                w_wr_en   = 1'b1;
                if (r_cnt != L_DEPTH) begin
                    w_cnt_nxt = r_cnt + (PW+1)'(1);
                end
            end else if (w_pop && w_cnt_nz) begin
                w_ptr_nxt = r_ptr - PW'(1);
                w_cnt_nxt = r_cnt - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_ras[w_wr_idx] <= pc_add_4;
        end
    end

endmodule

// File: tb/tb_branch_predictor_param.sv
// Randomised bench for branch_predictor_param: bimodal and gshare
// instances driven together and compared against a queue/array model.
module tb_branch_predictor_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, flush, B_type, jal, jalr;
    logic        upd_valid, upd_taken;
    logic [31:0] pc, pc_add_4, upd_pc;
    logic [4:0]  Rd, Rs1;
    logic [5:0]  upd_ghr;

    logic        pt0, pt1, rv0, rv1;
    logic [5:0]  pg0, pg1;
    logic [31:0] rt0, rt1;

    int n_run  = 0;
    int n_fail = 0;

    int pht [2][64];
    int ghr [2];
    int ras_q [$];

    always #5 clk = ~clk;

    branch_predictor_param #(.IDX_W(6), .GHR_W(6), .MODE(0), .RAS_DEPTH(4)) u_bim (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc(pc),
        .B_type(B_type), .jal(jal), .jalr(jalr), .Rd(Rd), .Rs1(Rs1),
        .pc_add_4(pc_add_4), .pred_taken(pt0), .pred_ghr(pg0),
        .ras_valid(rv0), .ras_target(rt0), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken)
    );

    branch_predictor_param #(.IDX_W(6), .GHR_W(6), .MODE(1), .RAS_DEPTH(4)) u_gsh (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc(pc),
        .B_type(B_type), .jal(jal), .jalr(jalr), .Rd(Rd), .Rs1(Rs1),
        .pc_add_4(pc_add_4), .pred_taken(pt1), .pred_ghr(pg1),
        .ras_valid(rv1), .ras_target(rt1), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pidx(int m, logic [31:0] a, int g);
        return int'(a[7:2]) ^ ((m != 0) ? g : 0);
    endfunction

    function automatic bit is_link(logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic bit m_push();
        return (jal || jalr) && is_link(Rd);
    endfunction

    function automatic bit m_pop();
        return jalr && is_link(Rs1) && !(is_link(Rd) && Rd == Rs1);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ghr[m] = 0;
            for (int i = 0; i < 64; i++) pht[m][i] = 1;
        end
        ras_q.delete();
    endtask

    task automatic clear();
        stall = 0; flush = 0; B_type = 0; jal = 0; jalr = 0;
        upd_valid = 0; upd_taken = 0; pc = 0; pc_add_4 = 0;
        upd_pc = 0; upd_ghr = 0; Rd = 0; Rs1 = 0;
    endtask

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            logic        g_pt, g_rv;
            logic [5:0]  g_pg;
            logic [31:0] g_rt;
            g_pt = (m == 0) ? pt0 : pt1;
            g_pg = (m == 0) ? pg0 : pg1;
            g_rv = (m == 0) ? rv0 : rv1;
            g_rt = (m == 0) ? rt0 : rt1;
            check($sformatf("pred_taken[m%0d]", m), g_pt,
                  pht[m][pidx(m, pc, ghr[m])] >= 2);
            check($sformatf("pred_ghr[m%0d]", m), g_pg, ghr[m]);
            check($sformatf("ras_valid[m%0d]", m), g_rv,
                  m_pop() && ras_q.size() > 0);
            if (ras_q.size() > 0)
                check($sformatf("ras_target[m%0d]", m), g_rt,
                      ras_q[ras_q.size()-1]);
        end
    endtask

    task automatic model_edge();
        int pt [2];
        for (int m = 0; m < 2; m++)
            pt[m] = (pht[m][pidx(m, pc, ghr[m])] >= 2) ? 1 : 0;
        for (int m = 0; m < 2; m++) begin
            if (upd_valid) begin
                int u;
                u = pidx(m, upd_pc, int'(upd_ghr));
                if (upd_taken) pht[m][u] = (pht[m][u] < 3) ? pht[m][u] + 1 : 3;
                else           pht[m][u] = (pht[m][u] > 0) ? pht[m][u] - 1 : 0;
            end
            if (flush)
                ghr[m] = upd_valid ? (((int'(upd_ghr) << 1) | int'(upd_taken)) & 63)
                                   : int'(upd_ghr);
            else if (!stall && B_type)
                ghr[m] = ((ghr[m] << 1) | pt[m]) & 63;
        end
        if (!stall && !flush) begin
            if (m_push() && m_pop() && ras_q.size() > 0) begin
                ras_q[ras_q.size()-1] = int'(pc_add_4);
            end else if (m_push()) begin
                ras_q.push_back(int'(pc_add_4));
                if (ras_q.size() > 4) void'(ras_q.pop_front());
            end else if (m_pop() && ras_q.size() > 0) begin
                void'(ras_q.pop_back());
            end
        end
    endtask

    task automatic cyc();
        #2;
        check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset(input bit busy);
        clear();
        if (busy) begin
            stall = 1; flush = 1; upd_valid = 1; upd_taken = 1;
            B_type = 1; jal = 1; Rd = 5'd1; pc_add_4 = 32'h1234;
            upd_ghr = 6'h3f;
        end
        rst = 1;
        #1;
        check("rst_pt0", pt0, 0);
        check("rst_pt1", pt1, 0);
        check("rst_ghr0", pg0, 0);
        check("rst_ghr1", pg1, 0);
        check("rst_rv", rv1, 0);
        check("rst_rt0", rt0, 0);
        check("rst_rt1", rt1, 0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_ghr", pg1, 0);
        check("rst_hold_rt", rt1, 0);
        @(negedge clk);
        rst = 0;
        clear();
    endtask

    task automatic rand_inputs();
        int op;
        clear();
        op = $urandom_range(0, 9);
        B_type = (op <= 3);
        jal    = (op == 4 || op == 5);
        jalr   = (op >= 6 && op <= 8);
        Rd  = pick_reg();
        Rs1 = pick_reg();
        pc        = $urandom & 32'hffff_fffc;
        pc_add_4  = $urandom;
        stall     = ($urandom_range(0, 7) == 0);
        flush     = ($urandom_range(0, 9) == 0);
        upd_valid = $urandom_range(0, 1);
        upd_taken = $urandom_range(0, 1);
        upd_pc    = $urandom & 32'hffff_fffc;
        upd_ghr   = 6'($urandom);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        clear();
        do_reset(0);

        pc = 32'h40; B_type = 1;
        #1;
        check("first_pred", pt1, 0);
        check("first_ghr", pg1, 0);
        cyc();
        clear();
        #1;
        check("ghr_after_b", pg1, 0);

        pc = 32'h40; upd_valid = 1; upd_pc = 32'h40; upd_taken = 1;
        repeat (3) cyc();
        #1;
        check("bim_sat_taken", pt0, 1);
        upd_taken = 0;
        cyc();
        #1;
        check("bim_dec_one", pt0, 1);
        repeat (4) cyc();
        upd_valid = 0;
        #1;
        check("bim_sat_zero", pt0, 0);
        cyc();

        do_reset(0);
        upd_valid = 1; upd_pc = 32'h40; upd_ghr = 6'b000001; upd_taken = 1;
        repeat (3) cyc();
        clear();
        pc = 32'h40;
        #1;
        check("gsh_other_idx", pt1, 0);
        pc = 32'h44;
        #1;
        check("gsh_trained_idx", pt1, 1);
        cyc();

        clear();
        flush = 1; upd_valid = 1; upd_ghr = 6'b101010; upd_taken = 1;
        cyc();
        clear();
        #1;
        check("flush_ghr", pg1, 6'b010101);
        check("flush_ghr_bim", pg0, 6'b010101);
        stall = 1; B_type = 1; pc = 32'h44;
        repeat (2) cyc();
        #1;
        check("stall_hold", pg1, 6'b010101);
        clear();
        flush = 1; upd_ghr = 6'h2c;
        cyc();
        clear();
        #1;
        check("flush_no_upd", pg1, 6'h2c);

        do_reset(0);
        for (int i = 1; i <= 5; i++) begin
            jal = 1; Rd = 5'd1; pc_add_4 = i * 32'h100 + 32'h4;
            cyc();
        end
        clear();
        jalr = 1; Rs1 = 5'd1; Rd = 5'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("ras_pop_valid", rv0, 1);
            check("ras_pop_target", rt0, 32'h504 - k * 32'h100);
            cyc();
        end
        #1;
        check("ras_underflow", rv0, 0);
        cyc();
        clear();
        jal = 1; Rd = 5'd5; pc_add_4 = 32'h300;
        cyc();
        clear();
        jalr = 1; Rd = 5'd1; Rs1 = 5'd5; pc_add_4 = 32'h800;
        #1;
        check("coro_valid", rv0, 1);
        check("coro_target", rt0, 32'h300);
        cyc();
        clear();
        jalr = 1; Rs1 = 5'd1; Rd = 5'd0;
        #1;
        check("coro_top", rt0, 32'h800);
        check("coro_cnt_valid", rv0, 1);
        cyc();
        #1;
        check("coro_cnt_empty", rv0, 0);
        cyc();

        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(1);
            rand_inputs();
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
